queue_cmd_sequencer: RTL and testbench

Initiator that drives the calculator operand queue. It accepts a stream of number/operator tokens over a valid/ready handshake and translates each token into queue opcodes. For operators it computes the ALU result from the queue's front pair and writes that result back into the queue. At the end of a program it reports the single remaining value, or flags an error.

---
 rtl/calc_q_pkg.sv | 26 ++
 rtl/calc_q_alu.sv | 24 ++
 rtl/queue_cmd_sequencer.sv | 153 +++++++++++++++
 tb/tb_queue_cmd_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_q_pkg.sv
// Shared definitions for the calculator operand queue and its command sequencer.
package calc_q_pkg;

    localparam int unsigned QUEUE_DEPTH = 5;

    // Queue command encodings
    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_NOP  = 2'b01;
    localparam logic [1:0] OP_PAIR = 2'b10;
    localparam logic [1:0] OP_POP  = 2'b11;

    // ALU function codes carried in tok_data[1:0] of operator tokens
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StPush,
        StExec,
        StResult,
        StErr
    } state_e;

endpackage

// File: rtl/calc_q_alu.sv
// Combinational W-bit ALU; all results wrap modulo 2^W.
module calc_q_alu
    import calc_q_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   func,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        unique case (func)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_MUL: y = a * b;
            ALU_XOR: y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/queue_cmd_sequencer.sv
// Translates number/operator tokens into operand-queue commands and reports the
// final value of each program, or a sticky error.
module queue_cmd_sequencer
    import calc_q_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = QUEUE_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tok_valid,
    input  logic           tok_is_op,
    input  logic [W-1:0]   tok_data,
    input  logic           tok_last,
    output logic           tok_ready,
    output logic [1:0]     q_opcode,
    output logic [W-1:0]   q_back,
    input  logic [2*W-1:0] q_top_conc,
    input  logic [W-1:0]   q_tail,
    input  logic           q_is_err,
    output logic           res_valid,
    output logic [W-1:0]   res_data,
    output logic           err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [CW-1:0] CntTwo  = CW'(2);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    opcode_q, opcode_d;
    logic [W-1:0]  back_q, back_d;
    logic [1:0]    op_q, op_d;
    logic          last_q, last_d;
    logic          res_valid_q, res_valid_d;
    logic [W-1:0]  res_data_q, res_data_d;
    logic          err_q, err_d;
    logic [W-1:0]  alu_y;

    calc_q_alu #(
        .W (W)
    ) u_alu (
        .a    (q_top_conc[2*W-1:W]),
        .b    (q_top_conc[W-1:0]),
        .func (op_q),
        .y    (alu_y)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opcode_d    = OP_NOP;
        back_d      = back_q;
        op_d        = op_q;
        last_d      = last_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;

        unique case (state_q)
            StIdle: begin
                if (tok_valid) begin
                    last_d = tok_last;
                    if (tok_is_op) begin
                        op_d = tok_data[1:0];
                        if (cnt_q < CntTwo) begin
                            state_d = StErr;
                        end else begin
                            state_d  = StExec;
                            opcode_d = OP_PAIR;
                        end
                    end else begin
                        back_d = tok_data;
                        if (cnt_q == CntFull) begin
                            state_d = StErr;
                        end else begin
                            state_d  = StPush;
                            opcode_d = OP_PUSH;
                        end
                    end
                end
            end
            StPush: begin
                cnt_d   = cnt_q + CntOne;
                state_d = last_q ? StResult : StIdle;
            end
            StExec: begin
                cnt_d   = cnt_q - CntOne;
                state_d = last_q ? StResult : StIdle;
            end
            StResult: begin
                if (cnt_q == CntOne) begin
                    cnt_d      = '0;
                    state_d    = StIdle;
                    res_data_d = q_tail;
                end else begin
                    state_d = StErr;
                end
            end
            StErr: state_d = StErr;
            default: state_d = StErr;
        endcase

        // The drain pop and result strobe are registered so they coincide with RESULT.
        if (state_d == StResult && cnt_d == CntOne) begin
            opcode_d    = OP_POP;
            res_valid_d = 1'b1;
        end

        if (q_is_err) begin
            state_d     = StErr;
            opcode_d    = OP_NOP;
            res_valid_d = 1'b0;
        end

        err_d = err_q | (state_d == StErr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            opcode_q    <= OP_NOP;
            back_q      <= '0;
            op_q        <= ALU_ADD;
            last_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opcode_q    <= opcode_d;
            back_q      <= back_d;
            op_q        <= op_d;
            last_q      <= last_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
        end
    end

    assign tok_ready = (state_q == StIdle);
    assign q_opcode  = opcode_q;
    // The pair-replace value follows the live queue front, not a snapshot.
    assign q_back    = (state_q == StExec) ? alu_y : back_q;
    assign res_valid = res_valid_q;
    // During the strobe the result is read straight from the queue tail.
    assign res_data  = res_valid_q ? q_tail : res_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_queue_cmd_sequencer.sv
// Directed bench: a behavioural operand queue closes the loop around the sequencer.
module tb_queue_cmd_sequencer;

    localparam int W = 8;
    localparam int DEPTH = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           tok_valid = 1'b0;
    logic           tok_is_op = 1'b0;
    logic [W-1:0]   tok_data = '0;
    logic           tok_last = 1'b0;
    logic           tok_ready;
    logic [1:0]     q_opcode;
    logic [W-1:0]   q_back;
    logic [2*W-1:0] q_top_conc;
    logic [W-1:0]   q_tail;
    logic           q_is_err;
    logic           res_valid;
    logic [W-1:0]   res_data;
    logic           err;

    logic [W-1:0]   qm [0:DEPTH-1];
    int             qn;
    logic           qerr;
    logic           inject_err = 1'b0;

    logic [1:0]     ops [$];
    logic [W-1:0]   backs [$];
    int             nres;
    logic [W-1:0]   last_res;

    int n_checks = 0;
    int n_fail = 0;

    queue_cmd_sequencer #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tok_valid  (tok_valid),
        .tok_is_op  (tok_is_op),
        .tok_data   (tok_data),
        .tok_last   (tok_last),
        .tok_ready  (tok_ready),
        .q_opcode   (q_opcode),
        .q_back     (q_back),
        .q_top_conc (q_top_conc),
        .q_tail     (q_tail),
        .q_is_err   (q_is_err),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Behavioural queue: front is entry 0, pair-replace writes the result at the front.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qn   <= 0;
            qerr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) qm[i] <= '0;
        end else begin
            case (q_opcode)
                2'b00: begin
                    if (qn == DEPTH) qerr <= 1'b1;
                    else begin
                        qm[qn] <= q_back;
                        qn     <= qn + 1;
                    end
                end
                2'b10: begin
                    if (qn < 2) qerr <= 1'b1;
                    else begin
                        qm[0] <= q_back;
                        for (int i = 1; i < DEPTH - 1; i++) qm[i] <= qm[i+1];
                        qn <= qn - 1;
                    end
                end
                2'b11: begin
                    if (qn == 0) qerr <= 1'b1;
                    else begin
                        for (int i = 0; i < DEPTH - 1; i++) qm[i] <= qm[i+1];
                        qn <= qn - 1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q_top_conc = {qm[0], qm[1]};
    assign q_tail     = (qn > 0) ? qm[qn-1] : '0;
    assign q_is_err   = qerr | inject_err;

    always @(negedge clk) begin
        if (!rst) begin
            if (q_opcode != 2'b01) begin
                ops.push_back(q_opcode);
                backs.push_back(q_back);
            end
            if (res_valid) begin
                nres = nres + 1;
                last_res = res_data;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        ops.delete();
        backs.delete();
        nres = 0;
        last_res = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_log();
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic is_op, input logic [W-1:0] d, input logic last);
        int n = 0;
        while (!tok_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("tok_ready_wait", {31'd0, n < 20}, 32'd1);
        if (n < 20) begin
            tok_valid = 1'b1;
            tok_is_op = is_op;
            tok_data  = d;
            tok_last  = last;
            @(negedge clk);
            tok_valid = 1'b0;
            tok_last  = 1'b0;
        end
    endtask

    task automatic run_prog(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] op,
                            input logic [W-1:0] exp, input string tag);
        clear_log();
        send(1'b0, x, 1'b0);
        send(1'b0, y, 1'b0);
        send(1'b1, {6'd0, op}, 1'b1);
        repeat (3) @(negedge clk);
        chk({tag, "_nres"}, nres, 1);
        chk({tag, "_res"}, last_res, exp);
        chk({tag, "_pair_back"}, backs[2], exp);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        clear_log();
        @(negedge clk);
        chk("rst_opcode", q_opcode, 2'b01);
        chk("rst_err", err, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_q_back", q_back, 0);
        chk("rst_res_data", res_data, 0);
        rst = 1'b0;
        #1;
        chk("rst_tok_ready", tok_ready, 1);
        @(negedge clk);

        // Add: 3, 4, + (last)
        clear_log();
        send(1'b0, 8'd3, 1'b0);
        send(1'b0, 8'd4, 1'b0);
        send(1'b1, 8'd0, 1'b1);
        chk("add_busy_ready", tok_ready, 0);
        repeat (3) @(negedge clk);
        chk("add_nops", ops.size(), 4);
        chk("add_op0", ops[0], 2'b00);
        chk("add_back0", backs[0], 3);
        chk("add_op1", ops[1], 2'b00);
        chk("add_back1", backs[1], 4);
        chk("add_op2", ops[2], 2'b10);
        chk("add_back2", backs[2], 7);
        chk("add_op3", ops[3], 2'b11);
        chk("add_nres", nres, 1);
        chk("add_res", last_res, 7);
        chk("add_res_hold", res_data, 7);
        chk("add_q_empty", qn, 0);
        chk("add_ready", tok_ready, 1);

        run_prog(8'd200, 8'd100, 2'b00, 8'd44, "wrap_add");
        run_prog(8'd5, 8'd9, 2'b01, 8'd252, "wrap_sub");
        run_prog(8'd16, 8'd17, 2'b10, 8'd16, "wrap_mul");
        run_prog(8'h0F, 8'h3C, 2'b11, 8'h33, "xor");

        // Overflow: six numbers, no operator
        clear_log();
        for (int i = 1; i <= 6; i++) send(1'b0, 8'(i * 10), 1'b0);
        chk("ovf_err", err, 1);
        chk("ovf_npush", ops.size(), 5);
        chk("ovf_qerr", qerr, 0);
        repeat (4) @(negedge clk);
        chk("ovf_ready_low", tok_ready, 0);
        chk("ovf_err_sticky", err, 1);
        do_reset();

        // Underflow: 7 then operator
        send(1'b0, 8'd7, 1'b0);
        send(1'b1, 8'd0, 1'b0);
        repeat (2) @(negedge clk);
        chk("udf_err", err, 1);
        chk("udf_nops", ops.size(), 1);
        chk("udf_qerr", qerr, 0);
        do_reset();

        // Leftover: 1, 2 with last on 2
        send(1'b0, 8'd1, 1'b0);
        send(1'b0, 8'd2, 1'b1);
        repeat (3) @(negedge clk);
        chk("left_err", err, 1);
        chk("left_nres", nres, 0);
        chk("left_nops", ops.size(), 2);
        do_reset();

        // Reset while a pair-replace is on the bus
        send(1'b0, 8'd1, 1'b0);
        send(1'b0, 8'd2, 1'b0);
        send(1'b1, 8'd0, 1'b0);
        chk("mid_exec_opcode", q_opcode, 2'b10);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_opcode", q_opcode, 2'b01);
        chk("mid_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        send(1'b0, 8'd9, 1'b1);
        repeat (2) @(negedge clk);
        chk("mid_single_nres", nres, 1);
        chk("mid_single_res", last_res, 9);
        chk("mid_single_err", err, 0);

        // Queue-side error forces ERR from IDLE
        inject_err = 1'b1;
        @(negedge clk);
        inject_err = 1'b0;
        chk("qerr_err", err, 1);
        chk("qerr_ready", tok_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
